// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// one-entry output register with valid/ready handshake, overrun and framing flags.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             fe_q, fe_d;
  logic             rx_meta_q, rx_s_q;
  logic             deliver;
  logic             handshake;

  assign handshake = valid_q & ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = 1'b0;
    deliver = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise.
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BRK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BRK: begin
        // A held-low line must return high before a new start bit is accepted.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign overrun     = ovr_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level reference model driven by scheduled
// stop-bit events, per-cycle output comparison, directed and random frames.
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Stop-sample edge relative to the cycle the start bit is driven:
  // 2 synchronizer edges + 1 IDLE detect edge + half bit + 9 full bits.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_error(frame_error),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scheduled frame outcomes keyed by the posedge index of the stop sample.
  int         ev_kind  [int];
  logic [7:0] ev_byte  [int];
  int         ev_start [int];

  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_fe    = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         rst_cyc = -1;
  int         mk;
  logic       m_good, m_bad, m_hs;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_fe    = 1'b0;
      m_data  = 8'h00;
      rst_cyc = cyc;
    end else begin
      mk     = cyc + 1;
      m_good = ev_kind.exists(mk) && ev_start[mk] > rst_cyc && ev_kind[mk] == 1;
      m_bad  = ev_kind.exists(mk) && ev_start[mk] > rst_cyc && ev_kind[mk] == 2;
      m_hs   = m_valid && ready;
      m_fe   = m_bad;
      if (m_good) begin
        if (!m_valid || ready) begin
          m_data  = ev_byte[mk];
          m_valid = 1'b1;
          m_ovr   = 1'b0;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_hs) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  end

  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  bit         rnd_ready = 1'b0;
  int         rises, vld_ticks, fe_cnt, last_rise_cyc, last_start;
  bit         ovr_seen, busy_seen, prev_v;
  logic [7:0] last_rise_data;
  logic [7:0] rd [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic reset_stats();
    rises = 0; vld_ticks = 0; fe_cnt = 0; ovr_seen = 0; busy_seen = 0;
    for (int i = 0; i < 8; i++) rd[i] = 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en)
      check($sformatf("cyc%0d_outputs", cyc), {valid, data, overrun, frame_error},
            {m_valid, m_data, m_ovr, m_fe});
    if (valid && !prev_v) begin
      if (rises < 8) rd[rises] = data;
      rises++;
      last_rise_cyc  = cyc;
      last_rise_data = data;
    end
    prev_v = valid;
    if (valid) vld_ticks++;
    if (frame_error) fe_cnt++;
    if (overrun) ovr_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; optionally pulses
  // reset in the middle of data bit rst_bit. Leaves rx at the stop value.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rst_bit);
    int c;
    tick();
    rx = 1'b0;
    c  = cyc;
    last_start          = c;
    ev_kind[c + LAT]    = stop_ok ? 1 : 2;
    ev_byte[c + LAT]    = b;
    ev_start[c + LAT]   = c;
    repeat (CPB - 1) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      rx = b[i];
      if (i == rst_bit) begin
        repeat (HALF) tick();
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {valid, data, overrun, frame_error, busy}, 12'h000);
        tick();
        tick();
        reset = 1'b0;
        repeat (CPB - 1 - HALF - 2) tick();
      end else begin
        repeat (CPB - 1) tick();
      end
    end
    tick();
    rx = stop_ok;
    repeat (CPB - 1) tick();
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    prev_v = 1'b0;
    last_rise_cyc = 0;
    last_start = 0;
    last_rise_data = 8'h00;
    reset_stats();
    repeat (3) tick();
    check("reset_outputs", {valid, data, overrun, frame_error, busy}, 12'h000);
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    idle(10);

    // Single good frame
    reset_stats();
    send_frame(8'h55, 1'b1, -1);
    idle(20);
    check("f55_rises", rises, 1);
    check("f55_data", last_rise_data, 8'h55);
    check("f55_valid_len", vld_ticks, 1);
    check("f55_frame_error", fe_cnt, 0);
    check("f55_busy_seen", busy_seen, 1);
    check("f55_latency_ok", ((last_rise_cyc - last_start) >= 1 + HALF + 9 * CPB) &&
                            ((last_rise_cyc - last_start) <= 3 + HALF + 9 * CPB), 1);
    check("f55_idle_busy", busy, 0);

    // Short low glitch is rejected
    reset_stats();
    tick();
    rx = 1'b0;
    repeat (3) tick();
    tick();
    rx = 1'b1;
    idle(30);
    check("glitch_rises", rises, 0);
    check("glitch_fe", fe_cnt, 0);
    check("glitch_data", data, 8'h55);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_idle_busy", busy, 0);

    // Bad stop bit, line held low, then a clean frame
    reset_stats();
    send_frame(8'hA3, 1'b0, -1);
    repeat (40) tick();
    check("brk_busy_low", busy, 1);
    check("brk_fe_pulses", fe_cnt, 1);
    check("brk_no_valid", rises, 0);
    tick();
    rx = 1'b1;
    idle(10);
    check("brk_released", busy, 0);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);
    check("brk_next_rises", rises, 1);
    check("brk_next_data", last_rise_data, 8'h3C);

    // Overrun with consumer stalled
    ready = 1'b0;
    reset_stats();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(20);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 8'h11);
    check("ovr_flag", overrun, 1);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("ovr_hs_valid", valid, 0);
    check("ovr_hs_flag", overrun, 0);
    check("ovr_hs_data", data, 8'h11);
    ready = 1'b1;
    idle(5);

    // Reset in the middle of a frame
    reset_stats();
    send_frame(8'hF0, 1'b1, 4);
    idle(20);
    check("rst_no_valid", rises, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 8'h00);
    check("rst_busy", busy, 0);
    send_frame(8'h5A, 1'b1, -1);
    idle(20);
    check("rst_next_rises", rises, 1);
    check("rst_next_data", last_rise_data, 8'h5A);

    // Back-to-back frames
    reset_stats();
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h80, 1'b1, -1);
    idle(20);
    check("b2b_rises", rises, 2);
    check("b2b_first", rd[0], 8'h01);
    check("b2b_second", rd[1], 8'h80);
    check("b2b_overrun", ovr_seen, 0);
    check("b2b_fe", fe_cnt, 0);

    // Random frames, stop bits, gaps, glitches and consumer stalls
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [7:0] b;
      b    = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        tick();
        rx = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        tick();
        rx = 1'b1;
        idle(20);
      end else if (kind == 1) begin
        send_frame(b, 1'b0, -1);
        repeat ($urandom_range(0, 30)) tick();
        tick();
        rx = 1'b1;
        idle($urandom_range(4, 20));
      end else begin
        send_frame(b, 1'b1, -1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 30));
      end
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
